// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store per req/ready handshake, a fixed number of wait states, response on rvalid/rready.
// Optional byte-lane stores are compiled in with `define DMEM_BYTE_ENABLE_EN (DATA_WIDTH must then be 32).
module dmem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 256,
  parameter int WAIT_STATES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            be_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept, access;

  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [AW-1:0]         acc_idx;
  logic                  acc_err;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    ready_o   = 1'b0;
    rvalid_o  = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Zero-wait accesses happen on the acceptance edge, so they use the live inputs.
  always_comb begin
    acc_we    = (state == IDLE) ? we_i    : we_q;
    acc_addr  = (state == IDLE) ? addr_i  : addr_q;
    acc_wdata = (state == IDLE) ? wdata_i : wdata_q;
    acc_idx   = acc_addr[AW+1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != '0);
  end

`ifdef DMEM_BYTE_ENABLE_EN
  logic [3:0] be_q;
  logic [3:0] acc_be;

  always_ff @(posedge clk) begin
    if (reset)       be_q <= '0;
    else if (accept) be_q <= be_i;
  end

  assign acc_be = (state == IDLE) ? be_i : be_q;

  always_ff @(posedge clk) begin
    if (!reset && access && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be_i;

  always_ff @(posedge clk) begin
    if (!reset && access && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end
`endif

  // Registered read; stores and errors report zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else if (access) begin
      err_o   <= acc_err;
      rdata_o <= (acc_we || acc_err) ? '0 : mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a 2-wait-state and a 0-wait-state instance checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS0   = 2;
  localparam int WS1   = 0;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        req    [2];
  logic        we     [2];
  logic        rready [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic        err    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic [3:0]  be     [2];

  logic [31:0] mdl [2][DEPTH];
  logic [3:0]  kn  [2][DEPTH];

  int errs   = 0;
  int checks = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut_ws2 (
    .clk(clk), .reset(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
    .rready_i(rready[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut_ws0 (
    .clk(clk), .reset(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
    .rready_i(rready[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL dut%0d %s at %0t: got %h expected %h", cur, tag, $time, got, exp);
    end
  endtask

  // Reference store: applies enabled bytes of a legal word store.
  task automatic model_store(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
    int idx;
    idx = int'(a / 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_BYTE_ENABLE_EN
      if (b[i]) begin
`else
      if (b[i] || !b[i]) begin
`endif
        mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
        kn[d][idx][i] = 1'b1;
      end
    end
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input int hold, input bit hold_req, input logic [31:0] nxt_a);
    bit          exp_err, chk_rd;
    logic [31:0] exp_rd;
    int          lat;
    cur     = d;
    exp_err = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    exp_rd  = '0;
    chk_rd  = 1'b1;
    if (!exp_err) begin
      if (w) model_store(d, a, wd, b);
      else if (kn[d][a / 4] == 4'hF) exp_rd = mdl[d][a / 4];
      else chk_rd = 1'b0;
    end
    check("ready_idle", 32'(ready[d]), 32'd1);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    @(posedge clk); #1;
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
    lat = 0;
    while (!rvalid[d] && lat < 20) begin
      check("ready_wait", 32'(ready[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(ws_of(d)));
    check("err", 32'(err[d]), 32'(exp_err));
    if (chk_rd) check("rdata", rdata[d], exp_rd);
    for (int h = 0; h < hold; h++) begin
      if (hold_req) begin
        req[d] = 1'b1; we[d] = 1'b0; addr[d] = nxt_a;
      end
      @(posedge clk); #1;
      check("hold_rvalid", 32'(rvalid[d]), 32'd1);
      check("hold_ready", 32'(ready[d]), 32'd0);
      check("hold_err", 32'(err[d]), 32'(exp_err));
      if (chk_rd) check("hold_rdata", rdata[d], exp_rd);
    end
    rready[d] = 1'b1;
    @(posedge clk); #1;
    rready[d] = 1'b0;
    check("rvalid_drop", 32'(rvalid[d]), 32'd0);
    check("ready_reopen", 32'(ready[d]), 32'd1);
  endtask

  // Store, then reset k edges after acceptance (req and rready also high on the reset edge).
  task automatic store_then_reset(input int d, input logic [31:0] a, input logic [31:0] wd, input int k);
    cur = d;
    check("ready_pre_rst", 32'(ready[d]), 32'd1);
    req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = wd; be[d] = 4'hF;
    @(posedge clk); #1;
    req[d] = 1'b0;
    for (int j = 1; j < k; j++) begin
      @(posedge clk); #1;
    end
    rst[d] = 1'b1; req[d] = 1'b1; rready[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0; req[d] = 1'b0; rready[d] = 1'b0;
    if (k - 1 >= ws_of(d)) model_store(d, a, wd, 4'hF);
    check("rst_rvalid", 32'(rvalid[d]), 32'd0);
    check("rst_ready", 32'(ready[d]), 32'd1);
    check("rst_rdata", rdata[d], 32'd0);
    check("rst_err", 32'(err[d]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int sel, idx;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; rready[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mdl[d][i] = '0;
        kn[d][i]  = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      check("reset_ready", 32'(ready[d]), 32'd1);
      check("reset_rvalid", 32'(rvalid[d]), 32'd0);
      check("reset_rdata", rdata[d], 32'd0);
      check("reset_err", 32'(err[d]), 32'd0);
      rst[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0, '0);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h10, '0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h12, '0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h400, '0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b1, 32'h12, 32'hBAD0BAD0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b1, 32'h404, 32'hBAD1BAD1, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h10, '0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h4, '0, 4'hF, 0, 1'b0, '0);

    txn(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h3FC, '0, 4'hF, 0, 1'b0, '0);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h20, '0, 4'hF, 0, 1'b0, '0);
    txn(0, 1'b1, 32'h24, 32'h99999999, 4'b0000, 0, 1'b0, '0);
    txn(0, 1'b0, 32'h24, '0, 4'hF, 0, 1'b0, '0);

    txn(0, 1'b0, 32'h10, '0, 4'hF, 5, 1'b1, 32'h20);
    txn(0, 1'b0, 32'h20, '0, 4'hF, 0, 1'b0, '0);

    txn(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 0, 1'b0, '0);
    store_then_reset(0, 32'h30, 32'h00000055, 1);
    txn(0, 1'b0, 32'h30, '0, 4'hF, 0, 1'b0, '0);
    store_then_reset(0, 32'h34, 32'h00000066, 3);
    txn(0, 1'b0, 32'h34, '0, 4'hF, 0, 1'b0, '0);

    txn(1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, 0, 1'b0, '0);
    txn(1, 1'b0, 32'h40, '0, 4'hF, 0, 1'b0, '0);
    txn(1, 1'b0, 32'h42, '0, 4'hF, 2, 1'b1, 32'h40);
    txn(1, 1'b0, 32'h40, '0, 4'hF, 0, 1'b0, '0);
    store_then_reset(1, 32'h44, 32'h00000077, 1);
    txn(1, 1'b0, 32'h44, '0, 4'hF, 0, 1'b0, '0);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        sel = int'($urandom_range(0, 9));
        idx = int'($urandom_range(0, 15));
        if (sel <= 6)      a = 32'(idx * 4);
        else if (sel == 7) a = 32'(idx * 4) + 32'($urandom_range(1, 3));
        else if (sel == 8) a = 32'h400 + 32'(idx * 4) + (32'($urandom_range(0, 255)) << 10);
        else               a = $urandom;
        txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
            int'($urandom_range(0, 2)), 1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
